iob_cfg: RTL and testbench

- Parametrised, synthesizable successor to the pass-gate I/O block.
- Connects one device pad to N_TRACKS routing tracks through explicit input, output and output-enable paths instead of bidirectional switches.
- Configuration arrives over a daisy-chainable serial chain and sits in a shadow register; a commit copies it to the active register, so the pad can be reconfigured while running.
- One instance per pad in the I/O ring; the chain is threaded pad to pad.

---
 rtl/iob_pkg.sv | 54 +++++
 rtl/iob_cfg_chain.sv | 84 ++++++++
 rtl/iob_cfg.sv | 113 +++++++++++
 tb/tb_iob_cfg.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iob_pkg.sv
// iob_pkg: shared definitions for the configurable I/O block.
// Holds the mode encodings, the chain FSM states and the config-word layout
// helpers used by the RTL, the bitstream generator and the bench.
// Optional feature macro: IOB_PULLUP_EN (adds a pull-up bit at the word MSB).
package iob_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'b00,
    MODE_IN    = 2'b01,
    MODE_OUT   = 2'b10,
    MODE_BIDIR = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_UNCFG  = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_ACTIVE = 2'd2
  } state_e;

  // Field offsets, LSB first: mode, osel, imask, ireg, oreg [, pull].
  localparam int OFF_MODE = 0;
  localparam int OFF_OSEL = 2;

  function automatic int sel_w(input int n);
    return $clog2(n);
  endfunction

  function automatic int off_imask(input int n);
    return OFF_OSEL + sel_w(n);
  endfunction

  function automatic int off_ireg(input int n);
    return off_imask(n) + n;
  endfunction

  function automatic int off_oreg(input int n);
    return off_ireg(n) + 1;
  endfunction

`ifdef IOB_PULLUP_EN
  function automatic int off_pull(input int n);
    return off_oreg(n) + 1;
  endfunction

  function automatic int cfg_w(input int n);
    return 5 + sel_w(n) + n;
  endfunction
`else
  function automatic int cfg_w(input int n);
    return 4 + sel_w(n) + n;
  endfunction
`endif

endpackage

// File: rtl/iob_cfg_chain.sv
// iob_cfg_chain: serial config chain with shadow/active registers and load FSM.
// Ports: clk/rst_n; cfg_en_i/cfg_din_i shift in, cfg_dout_o registered shadow MSB;
//   cfg_commit_i copies shadow to active_o; cfg_done_o = ACTIVE; cfg_err_o = rejected commit pulse.
module iob_cfg_chain
  import iob_pkg::*;
#(
  parameter int CFG_W = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_en_i,
  input  logic             cfg_din_i,
  input  logic             cfg_commit_i,
  output logic             cfg_dout_o,
  output logic             cfg_done_o,
  output logic             cfg_err_o,
  output logic [CFG_W-1:0] active_o
);

  localparam int CNT_W = $clog2(CFG_W + 1);

  logic [CFG_W-1:0] shadow_q, shadow_d;
  logic [CFG_W-1:0] active_q, active_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dout_q, dout_d;
  logic             err_q, err_d;
  state_e           state_q, state_d;
  logic             full;
  logic             accept;

  always_comb begin
    full     = (cnt_q == CNT_W'(CFG_W));
    // A commit is only honoured once a whole word has been shifted and the
    // chain is quiet in the same cycle; anything else is flagged.
    accept   = cfg_commit_i & ~cfg_en_i & full & (state_q == ST_SHIFT);
    shadow_d = shadow_q;
    active_d = active_q;
    cnt_d    = cnt_q;
    dout_d   = dout_q;
    err_d    = cfg_commit_i & ~accept;
    state_d  = state_q;

    if (cfg_en_i) begin
      shadow_d = {shadow_q[CFG_W-2:0], cfg_din_i};
      dout_d   = shadow_q[CFG_W-1];
      if (!full) cnt_d = cnt_q + CNT_W'(1);
    end
    if (accept) begin
      active_d = shadow_q;
      cnt_d    = '0;
    end

    case (state_q)
      ST_UNCFG:  if (cfg_en_i) state_d = ST_SHIFT;
      ST_SHIFT:  if (accept)   state_d = ST_ACTIVE;
      ST_ACTIVE: if (cfg_en_i) state_d = ST_SHIFT;
      default:                 state_d = ST_UNCFG;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
      active_q <= '0;
      cnt_q    <= '0;
      dout_q   <= 1'b0;
      err_q    <= 1'b0;
      state_q  <= ST_UNCFG;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      cnt_q    <= cnt_d;
      dout_q   <= dout_d;
      err_q    <= err_d;
      state_q  <= state_d;
    end
  end

  assign cfg_dout_o = dout_q;
  assign cfg_err_o  = err_q;
  assign cfg_done_o = (state_q == ST_ACTIVE);
  assign active_o   = active_q;

endmodule

// File: rtl/iob_cfg.sv
// iob_cfg: one pad connected to N_TRACKS routing tracks via explicit in/out/oe paths.
// Ports: cfg_* serial config chain (see iob_cfg_chain); trk_i/trk_o/trk_oe track side;
//   pad_i/pad_o/pad_oe pad side; pad_pu pull-up enable only when IOB_PULLUP_EN is defined.
module iob_cfg
  import iob_pkg::*;
#(
  parameter int N_TRACKS = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_en,
  input  logic                cfg_din,
  output logic                cfg_dout,
  input  logic                cfg_commit,
  output logic                cfg_done,
  output logic                cfg_err,
  input  logic [N_TRACKS-1:0] trk_i,
  output logic [N_TRACKS-1:0] trk_o,
  output logic [N_TRACKS-1:0] trk_oe,
  input  logic                pad_i,
  output logic                pad_o,
  output logic                pad_oe
`ifdef IOB_PULLUP_EN
  ,
  output logic                pad_pu
`endif
);

  localparam int SEL_W    = sel_w(N_TRACKS);
  localparam int CFG_W    = cfg_w(N_TRACKS);
  localparam int OFF_IMSK = off_imask(N_TRACKS);
  localparam int OFF_IREG = off_ireg(N_TRACKS);
  localparam int OFF_OREG = off_oreg(N_TRACKS);

  logic [CFG_W-1:0]    active;
  mode_e               mode;
  logic [SEL_W-1:0]    osel, osel_eff, osel_nxt;
  logic [N_TRACKS-1:0] imask;
  logic                ireg, oreg;
  logic                src, oe_src, in_v;
  logic                pad_o_q, pad_oe_q, pad_in_q;

  iob_cfg_chain #(.CFG_W(CFG_W)) u_chain (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_en_i     (cfg_en),
    .cfg_din_i    (cfg_din),
    .cfg_commit_i (cfg_commit),
    .cfg_dout_o   (cfg_dout),
    .cfg_done_o   (cfg_done),
    .cfg_err_o    (cfg_err),
    .active_o     (active)
  );

  assign mode  = mode_e'(active[OFF_MODE +: 2]);
  assign osel  = active[OFF_OSEL +: SEL_W];
  assign imask = active[OFF_IMSK +: N_TRACKS];
  assign ireg  = active[OFF_IREG];
  assign oreg  = active[OFF_OREG];

  // Out-of-range selects fold to track 0; only possible when N_TRACKS is not
  // a power of two.
  if (N_TRACKS == (1 << SEL_W)) begin : g_sel_pow2
    assign osel_eff = osel;
  end else begin : g_sel_clamp
    assign osel_eff = (osel < SEL_W'(N_TRACKS)) ? osel : '0;
  end

  // In BIDIR the drive enable comes from the neighbouring track, wrapping.
  assign osel_nxt = (osel_eff == SEL_W'(N_TRACKS - 1)) ? '0 : osel_eff + SEL_W'(1);

  always_comb begin
    src    = trk_i[osel_eff];
    oe_src = 1'b0;
    case (mode)
      MODE_OUT:   oe_src = 1'b1;
      MODE_BIDIR: oe_src = trk_i[osel_nxt];
      default:    oe_src = 1'b0;
    endcase
    in_v = ireg ? pad_in_q : pad_i;
  end

  // Data flops run in every mode; OFF is handled by masking the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pad_o_q  <= 1'b0;
      pad_oe_q <= 1'b0;
      pad_in_q <= 1'b0;
    end else begin
      pad_o_q  <= src;
      pad_oe_q <= oe_src;
      pad_in_q <= pad_i;
    end
  end

  always_comb begin
    pad_o  = 1'b0;
    pad_oe = 1'b0;
    trk_o  = '0;
    trk_oe = '0;
    if (mode != MODE_OFF) begin
      pad_o  = oreg ? pad_o_q  : src;
      pad_oe = oreg ? pad_oe_q : oe_src;
      trk_o  = {N_TRACKS{in_v}} & imask;
      if (mode == MODE_IN || mode == MODE_BIDIR) trk_oe = imask;
    end
  end

`ifdef IOB_PULLUP_EN
  assign pad_pu = active[off_pull(N_TRACKS)] & ~pad_oe;
`endif

endmodule

// File: tb/tb_iob_cfg.sv
// tb_iob_cfg: self-checking bench for iob_cfg (two instances chained via cfg_dout).
// Latency: n/a (bench).
// Backpressure: n/a (bench).
module tb_iob_cfg;

`ifdef IOB_PULLUP_EN
  localparam int CFG_W = 16;
`else
  localparam int CFG_W = 15;
`endif

  logic       clk = 1'b0;
  logic       rst_n, cfg_en, cfg_din, cfg_commit;
  logic [7:0] trk_i;
  logic       pad_i, pad_i_b;
  logic       cfg_dout, cfg_done, cfg_err, pad_o, pad_oe;
  logic [7:0] trk_o, trk_oe;
  logic       dout_b, done_b, err_b, pad_o_b, pad_oe_b;
  logic [7:0] trk_o_b, trk_oe_b;
`ifdef IOB_PULLUP_EN
  logic       pad_pu, pad_pu_b;
`endif

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  iob_cfg #(.N_TRACKS(8)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_en(cfg_en), .cfg_din(cfg_din), .cfg_dout(cfg_dout),
    .cfg_commit(cfg_commit), .cfg_done(cfg_done), .cfg_err(cfg_err),
    .trk_i(trk_i), .trk_o(trk_o), .trk_oe(trk_oe),
    .pad_i(pad_i), .pad_o(pad_o), .pad_oe(pad_oe)
`ifdef IOB_PULLUP_EN
    , .pad_pu(pad_pu)
`endif
  );

  iob_cfg #(.N_TRACKS(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .cfg_en(cfg_en), .cfg_din(cfg_dout), .cfg_dout(dout_b),
    .cfg_commit(cfg_commit), .cfg_done(done_b), .cfg_err(err_b),
    .trk_i(trk_i), .trk_o(trk_o_b), .trk_oe(trk_oe_b),
    .pad_i(pad_i_b), .pad_o(pad_o_b), .pad_oe(pad_oe_b)
`ifdef IOB_PULLUP_EN
    , .pad_pu(pad_pu_b)
`endif
  );

  typedef struct {
    logic [1:0] mode;
    logic [2:0] osel;
    logic [7:0] imask;
    logic [7:0] trk;
    logic       pad;
    logic       po;
    logic       poe;
    logic [7:0] to;
    logic [7:0] toe;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [CFG_W-1:0] mk_cfg(input logic [1:0] md, input logic [2:0] os,
                                              input logic [7:0] im, input logic ir,
                                              input logic orr);
    logic [CFG_W-1:0] w;
    w = '0;
    w[14:0] = {orr, ir, im, os, md};
    return w;
  endfunction

  // Reference: outputs from the field rules, given current and previous-cycle inputs.
  function automatic logic [17:0] model(input logic [1:0] md, input logic [2:0] os,
                                        input logic [7:0] im, input logic ir, input logic orr,
                                        input logic [7:0] ct, input logic [7:0] pt,
                                        input logic cp, input logic pp);
    int   s, nx;
    logic src_c, src_p, oe_c, oe_p, v;
    logic po, poe;
    logic [7:0] to, toe;
    if (md == 2'd0) return '0;
    s     = int'(os);
    nx    = (s + 1) % 8;
    src_c = ct[s];
    src_p = pt[s];
    oe_c  = (md == 2'd2) ? 1'b1 : (md == 2'd3) ? ct[nx] : 1'b0;
    oe_p  = (md == 2'd2) ? 1'b1 : (md == 2'd3) ? pt[nx] : 1'b0;
    po    = orr ? src_p : src_c;
    poe   = orr ? oe_p : oe_c;
    v     = ir ? pp : cp;
    to    = v ? im : 8'h00;
    toe   = (md == 2'd1 || md == 2'd3) ? im : 8'h00;
    return {po, poe, to, toe};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic shift_bits(input logic [CFG_W-1:0] w, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) begin
      cfg_en  = 1'b1;
      cfg_din = w[i];
      step();
    end
    cfg_en  = 1'b0;
    cfg_din = 1'b0;
  endtask

  task automatic commit();
    cfg_commit = 1'b1;
    step();
    cfg_commit = 1'b0;
  endtask

  task automatic load_cfg(input logic [CFG_W-1:0] w);
    shift_bits(w, CFG_W - 1, 0);
    commit();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got still running, expected finished");
    $fatal;
  end

  initial begin
    logic [CFG_W-1:0] w, wa, wb;
    logic [2*CFG_W-1:0] stream;
    logic [1:0] md;
    logic [2:0] os;
    logic [7:0] im, ct, pt;
    logic       ir, orr, cp, pp;
    logic [17:0] e;

    //          mode  osel  imask  trk    pad   po    poe   trk_o  trk_oe
    tbl[0] = '{2'd2, 3'd3, 8'h00, 8'h08, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00};
    tbl[1] = '{2'd2, 3'd3, 8'h00, 8'hF7, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00};
    tbl[2] = '{2'd1, 3'd0, 8'hA5, 8'h01, 1'b1, 1'b1, 1'b0, 8'hA5, 8'hA5};
    tbl[3] = '{2'd1, 3'd0, 8'hA5, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'hA5};
    tbl[4] = '{2'd3, 3'd7, 8'h0F, 8'h01, 1'b1, 1'b0, 1'b1, 8'h0F, 8'h0F};
    tbl[5] = '{2'd3, 3'd5, 8'hF0, 8'h20, 1'b0, 1'b1, 1'b0, 8'h00, 8'hF0};
    tbl[6] = '{2'd0, 3'd2, 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00};

    rst_n = 1'b0; cfg_en = 1'b0; cfg_din = 1'b0; cfg_commit = 1'b0;
    trk_i = 8'h00; pad_i = 1'b0; pad_i_b = 1'b0;
    #12 rst_n = 1'b1;
    step();

    // Reset state, then idle with activity on the pad and tracks.
    chk("rst_pad_o", pad_o, 1'b0);
    chk("rst_pad_oe", pad_oe, 1'b0);
    chk("rst_trk_o", trk_o, 8'h00);
    chk("rst_trk_oe", trk_oe, 8'h00);
    chk("rst_done", cfg_done, 1'b0);
    chk("rst_err", cfg_err, 1'b0);
    chk("rst_dout", cfg_dout, 1'b0);
    for (int i = 0; i < 4; i++) begin
      pad_i = ~pad_i;
      trk_i = 8'($urandom);
      step();
      chk("idle_trk_oe", trk_oe, 8'h00);
      chk("idle_pad_o", pad_o, 1'b0);
    end

    // Table of combinational-path configurations.
    for (int i = 0; i < 7; i++) begin
      load_cfg(mk_cfg(tbl[i].mode, tbl[i].osel, tbl[i].imask, 1'b0, 1'b0));
      chk("tbl_done", cfg_done, 1'b1);
      trk_i = tbl[i].trk;
      pad_i = tbl[i].pad;
      #1;
      chk($sformatf("tbl%0d_pad_o", i), pad_o, tbl[i].po);
      chk($sformatf("tbl%0d_pad_oe", i), pad_oe, tbl[i].poe);
      chk($sformatf("tbl%0d_trk_o", i), trk_o, tbl[i].to);
      chk($sformatf("tbl%0d_trk_oe", i), trk_oe, tbl[i].toe);
    end

    // Registered BIDIR: OE from track 0 via wrap-around, input via flop.
    load_cfg(mk_cfg(2'd3, 3'd7, 8'h05, 1'b1, 1'b1));
    trk_i = 8'h00; pad_i = 1'b0;
    step(); step();
    chk("bidir_oe_idle", pad_oe, 1'b0);
    chk("bidir_trk_oe", trk_oe, 8'h05);
    trk_i = 8'h01; pad_i = 1'b1;
    #1;
    chk("bidir_oe_lat", pad_oe, 1'b0);
    chk("bidir_trk_o_lat", trk_o, 8'h00);
    step();
    chk("bidir_oe", pad_oe, 1'b1);
    chk("bidir_pad_o", pad_o, 1'b0);
    chk("bidir_trk_o", trk_o, 8'h05);

    // Short shift: commit rejected, old OUT/osel=3 config keeps driving.
    load_cfg(mk_cfg(2'd2, 3'd3, 8'h00, 1'b0, 1'b0));
    w = mk_cfg(2'd2, 3'd1, 8'h00, 1'b0, 1'b0);
    shift_bits(w, CFG_W - 1, 5);
    chk("short_done", cfg_done, 1'b0);
    commit();
    chk("short_err", cfg_err, 1'b1);
    chk("short_state", cfg_done, 1'b0);
    trk_i = 8'h08;
    #1;
    chk("short_keep_o", pad_o, 1'b1);
    chk("short_keep_oe", pad_oe, 1'b1);
    step();
    chk("short_err_pulse", cfg_err, 1'b0);
    shift_bits(w, 4, 0);
    commit();
    chk("full_err", cfg_err, 1'b0);
    chk("full_done", cfg_done, 1'b1);
    trk_i = 8'h02;
    #1;
    chk("full_new_sel", pad_o, 1'b1);
    trk_i = 8'h08;
    #1;
    chk("full_old_sel", pad_o, 1'b0);

    // Commit in ACTIVE with no shift since the last commit.
    commit();
    chk("nosh_err", cfg_err, 1'b1);
    chk("nosh_done", cfg_done, 1'b1);
    step();
    chk("nosh_err_pulse", cfg_err, 1'b0);

    // Commit together with the last shift: rejected, but the shift lands.
    w = mk_cfg(2'd1, 3'd0, 8'h3C, 1'b0, 1'b0);
    shift_bits(w, CFG_W - 1, 1);
    cfg_en = 1'b1; cfg_din = w[0]; cfg_commit = 1'b1;
    step();
    cfg_en = 1'b0; cfg_commit = 1'b0;
    chk("en_commit_err", cfg_err, 1'b1);
    chk("en_commit_done", cfg_done, 1'b0);
    commit();
    chk("en_late_err", cfg_err, 1'b0);
    chk("en_late_done", cfg_done, 1'b1);
    pad_i = 1'b1;
    #1;
    chk("en_late_trk_oe", trk_oe, 8'h3C);
    chk("en_late_trk_o", trk_o, 8'h3C);

    // Random configurations against the reference model.
    ct = trk_i; cp = pad_i;
    for (int c = 0; c < 8; c++) begin
      md  = 2'($urandom_range(0, 3));
      os  = 3'($urandom);
      im  = 8'($urandom);
      ir  = 1'($urandom);
      orr = 1'($urandom);
      load_cfg(mk_cfg(md, os, im, ir, orr));
      step();
      for (int k = 0; k < 12; k++) begin
        pt = ct; pp = cp;
        ct = 8'($urandom); cp = 1'($urandom);
        trk_i = ct; pad_i = cp;
        #1;
        e = model(md, os, im, ir, orr, ct, pt, cp, pp);
        chk("rnd_pad_o", pad_o, e[17]);
        chk("rnd_pad_oe", pad_oe, e[16]);
        chk("rnd_trk_o", trk_o, e[15:8]);
        chk("rnd_trk_oe", trk_oe, e[7:0]);
        step();
      end
    end

    // Two chained instances. cfg_dout is registered, so each IOB adds one
    // extra stage: B's word MSB is the reset value of A's cfg_dout (0), and
    // one filler bit sits between B's remaining bits and A's word.
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    step();
    wa = mk_cfg(2'd2, 3'd2, 8'h00, 1'b0, 1'b0);
    wb = mk_cfg(2'd1, 3'd0, 8'h81, 1'b0, 1'b0);
    stream = {wb[CFG_W-2:0], 1'b1, wa};
    for (int i = 2 * CFG_W - 1; i >= 0; i--) begin
      cfg_en = 1'b1; cfg_din = stream[i];
      step();
    end
    cfg_en = 1'b0; cfg_din = 1'b0;
    commit();
    chk("chain_done_a", cfg_done, 1'b1);
    chk("chain_done_b", done_b, 1'b1);
    trk_i = 8'h04; pad_i_b = 1'b1;
    #1;
    chk("chain_a_pad_o", pad_o, 1'b1);
    chk("chain_a_pad_oe", pad_oe, 1'b1);
    chk("chain_a_trk_oe", trk_oe, 8'h00);
    chk("chain_b_trk_o", trk_o_b, 8'h81);
    chk("chain_b_trk_oe", trk_oe_b, 8'h81);
    chk("chain_b_pad_oe", pad_oe_b, 1'b0);
    trk_i = 8'h00; pad_i_b = 1'b0;
    #1;
    chk("chain_a_pad_o0", pad_o, 1'b0);
    chk("chain_b_trk_o0", trk_o_b, 8'h00);

    // Reset mid-shift while driving in OUT mode.
    load_cfg(mk_cfg(2'd2, 3'd2, 8'h00, 1'b0, 1'b0));
    trk_i = 8'h04;
    #1;
    chk("mid_pre_oe", pad_oe, 1'b1);
    w = mk_cfg(2'd1, 3'd0, 8'h11, 1'b0, 1'b0);
    shift_bits(w, CFG_W - 1, 8);
    cfg_en = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_oe", pad_oe, 1'b0);
    chk("mid_rst_pad_o", pad_o, 1'b0);
    chk("mid_rst_done", cfg_done, 1'b0);
    cfg_en = 1'b0;
    step();
    rst_n = 1'b1;
    commit();
    chk("mid_uncfg_err", cfg_err, 1'b1);
    chk("mid_uncfg_done", cfg_done, 1'b0);
    load_cfg(w);
    pad_i = 1'b1;
    #1;
    chk("mid_reload_oe", trk_oe, 8'h11);
    chk("mid_reload_pad_oe", pad_oe, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
